// File: rtl/cam_tx_pkg.sv
// Shared types and constants for the camera test-pattern transmitter.
package cam_tx_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_FCNT  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        VBLANK = 2'd2
    } state_t;

    localparam logic [11:0] BAR_STEP = 12'h249;

    // Channel mask per bar, bit order {G,R,B}: black, blue, red, magenta, green, cyan, yellow, white.
    localparam logic [7:0][2:0] BAR_GRB = {
        3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000
    };

endpackage

// File: rtl/cam_tx_pixel_gen.sv
// Combinational pixel value for the test patterns.
// Define CAM_TX_BAYER_EN to turn the colour bars into a Bayer mosaic (GR/BG).
module cam_tx_pixel_gen
    import cam_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int DATA_W   = 12,
    parameter int H_W      = 10,
    parameter int V_W      = 9
) (
    input  logic [H_W-1:0]    h,
    input  logic [V_W-1:0]    v,
    input  mode_t             mode,
    input  logic [DATA_W-1:0] fcnt,
    output logic [DATA_W-1:0] pix
);

    logic [2:0]        bar;
    logic              chk;
    logic [DATA_W-1:0] bar_pix;

    always_comb begin
        bar = 3'(32'(h) / 32'(H_ACTIVE / 8));
        chk = |(((32'(h) ^ 32'(v)) >> 3) & 32'd1);
`ifdef CAM_TX_BAYER_EN
        // Mosaic row 0 is G R, row 1 is B G.
        unique case ({v[0], h[0]})
            2'b01:   bar_pix = BAR_GRB[bar][1] ? '1 : '0;
            2'b10:   bar_pix = BAR_GRB[bar][0] ? '1 : '0;
            default: bar_pix = BAR_GRB[bar][2] ? '1 : '0;
        endcase
`else
        bar_pix = DATA_W'(12'(bar) * BAR_STEP);
`endif
        unique case (mode)
            MODE_RAMP:  pix = DATA_W'(h);
            MODE_BARS:  pix = bar_pix;
            MODE_CHECK: pix = chk ? '1 : '0;
            default:    pix = fcnt;
        endcase
    end

endmodule

// File: rtl/cam_pattern_tx.sv
// Parallel camera-interface transmitter emitting synthetic test-pattern frames.
// Optional Bayer colour bars are selected with CAM_TX_BAYER_EN (see cam_tx_pixel_gen).
module cam_pattern_tx
    import cam_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              cam_pixclk,
    output logic              cam_fval,
    output logic              cam_lval,
    output logic [DATA_W-1:0] cam_d,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int V_MAX = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int H_W   = $clog2(H_TOT + 1);
    localparam int V_W   = $clog2(V_MAX + 1);

    state_t            state, nstate;
    logic [H_W-1:0]    h, nh;
    logic [V_W-1:0]    v, nv;
    mode_t             mode_l, nmode;
    logic [DATA_W-1:0] fcnt_l, nfcnt;
    logic              h_last, frame_end, lval_n;
    logic [DATA_W-1:0] pix;

    // Next position; outputs are registered from it so they line up with the counters.
    always_comb begin
        nstate    = state;
        nh        = h;
        nv        = v;
        nmode     = mode_l;
        nfcnt     = fcnt_l;
        frame_end = 1'b0;
        h_last    = (h == H_W'(H_TOT - 1));
        unique case (state)
            IDLE: begin
                if (enable) begin
                    nstate = ACTIVE;
                    nh     = '0;
                    nv     = '0;
                    nmode  = mode_t'(mode);
                    nfcnt  = DATA_W'(frame_cnt);
                end
            end
            ACTIVE: begin
                nh = h_last ? '0 : h + H_W'(1);
                if (h_last) begin
                    if (v == V_W'(V_ACTIVE - 1)) begin
                        nstate    = VBLANK;
                        nv        = '0;
                        frame_end = 1'b1;
                    end else begin
                        nv = v + V_W'(1);
                    end
                end
            end
            VBLANK: begin
                nh = h_last ? '0 : h + H_W'(1);
                if (h_last) begin
                    if (v == V_W'(V_BLANK - 1)) begin
                        nv = '0;
                        if (enable) begin
                            nstate = ACTIVE;
                            nmode  = mode_t'(mode);
                            nfcnt  = DATA_W'(frame_cnt);
                        end else begin
                            nstate = IDLE;
                        end
                    end else begin
                        nv = v + V_W'(1);
                    end
                end
            end
            default: nstate = IDLE;
        endcase
        lval_n = (nstate == ACTIVE) && (nh < H_W'(H_ACTIVE));
    end

    cam_tx_pixel_gen #(
        .H_ACTIVE (H_ACTIVE),
        .DATA_W   (DATA_W),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_pixel_gen (
        .h    (nh),
        .v    (nv),
        .mode (nmode),
        .fcnt (nfcnt),
        .pix  (pix)
    );

    // Everything but pixclk moves only while pixclk is high, i.e. just before it falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cam_pixclk <= 1'b0;
            cam_fval   <= 1'b0;
            cam_lval   <= 1'b0;
            cam_d      <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            state      <= IDLE;
            h          <= '0;
            v          <= '0;
            mode_l     <= MODE_RAMP;
            fcnt_l     <= '0;
        end else begin
            cam_pixclk <= ~cam_pixclk;
            frame_done <= 1'b0;
            if (cam_pixclk) begin
                state    <= nstate;
                h        <= nh;
                v        <= nv;
                mode_l   <= nmode;
                fcnt_l   <= nfcnt;
                cam_fval <= (nstate == ACTIVE);
                cam_lval <= lval_n;
                cam_d    <= lval_n ? pix : '0;
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Directed bench for cam_pattern_tx on a 16x4 active / 4 hblank / 2 vblank raster.
`timescale 1ns/1ps
module tb_cam_pattern_tx;

    localparam int HA   = 16;
    localparam int VA   = 4;
    localparam int HT   = 20;
    localparam int NPIX = 120;
`ifdef CAM_TX_BAYER_EN
    localparam logic [11:0] EXP_P4   = 12'h000;
    localparam logic [11:0] EXP_L1P2 = 12'hFFF;
`else
    localparam logic [11:0] EXP_P4   = 12'h492;
    localparam logic [11:0] EXP_L1P2 = 12'h249;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        cam_pixclk, cam_fval, cam_lval, frame_done;
    logic [11:0] cam_d;
    logic [15:0] frame_cnt;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_wide = 0;
    logic done_prev = 1'b0;

    logic        pf [NPIX];
    logic        pl [NPIX];
    logic [11:0] pd [NPIX];
    int          start_cyc;
    bit          cap_timeout;

    cam_pattern_tx #(
        .H_ACTIVE (16),
        .H_BLANK  (4),
        .V_ACTIVE (4),
        .V_BLANK  (2),
        .DATA_W   (12)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .cam_pixclk (cam_pixclk),
        .cam_fval   (cam_fval),
        .cam_lval   (cam_lval),
        .cam_d      (cam_d),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            if (done_prev) done_wide++;
        end
        done_prev = frame_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next receiver sampling point (just after a pixclk rise).
    task automatic next_pix();
        @(posedge clk); #1;
        if (!cam_pixclk) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        mode    = 2'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Record one frame (active lines + vblank) starting at the first FVAL-high sample.
    task automatic capture_frame(input int drop_at, input int chg_at, input logic [1:0] chg_mode);
        bit got;
        got = 1'b0;
        cap_timeout = 1'b0;
        for (int n = 0; n < 600; n++) begin
            next_pix();
            if (cam_fval) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            cap_timeout = 1'b1;
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < NPIX; i++) begin
            if (i > 0) next_pix();
            pf[i] = cam_fval;
            pl[i] = cam_lval;
            pd[i] = cam_d;
            if (i == drop_at) enable = 1'b0;
            if (i == chg_at) mode = chg_mode;
        end
    endtask

    task automatic test_reset();
        int toggles, bad;
        logic prev;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cam_pixclk !== 1'b0) begin failures++; $display("FAIL rst_pixclk got=%b exp=0", cam_pixclk); end
        checks++; if (cam_fval !== 1'b0) begin failures++; $display("FAIL rst_fval got=%b exp=0", cam_fval); end
        checks++; if (cam_lval !== 1'b0) begin failures++; $display("FAIL rst_lval got=%b exp=0", cam_lval); end
        checks++; if (cam_d !== 12'h000) begin failures++; $display("FAIL rst_d got=%h exp=000", cam_d); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", frame_done); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_fcnt got=%0d exp=0", frame_cnt); end
        reset_n = 1'b1;
        toggles = 0;
        bad = 0;
        prev = cam_pixclk;
        repeat (40) begin
            @(posedge clk); #1;
            if (cam_pixclk !== prev) toggles++;
            prev = cam_pixclk;
            if (cam_fval !== 1'b0 || cam_lval !== 1'b0 || cam_d !== 12'h000) bad++;
        end
        checks++; if (toggles !== 40) begin failures++; $display("FAIL pixclk_toggle got=%0d exp=40", toggles); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL idle_outputs bad=%0d exp=0", bad); end
    endtask

    task automatic test_framing();
        int s0, lc, n, i;
        do_reset();
        enable = 1'b1;
        capture_frame(-1, -1, 2'd0);
        checks++; if (cap_timeout !== 1'b0) begin failures++; $display("FAIL frame_start_timeout got=1 exp=0"); end
        s0 = start_cyc;
        for (int ln = 0; ln < VA; ln++) begin
            lc = 0;
            for (int x = 0; x < HT; x++) begin
                i = ln * HT + x;
                if (pl[i]) lc++;
                checks++;
                if (pf[i] !== 1'b1 || pl[i] !== (x < HA) || pd[i] !== ((x < HA) ? 12'(x) : 12'h000)) begin
                    failures++;
                    $display("FAIL ramp_l%0d_p%0d got fval=%b lval=%b d=%h exp fval=1 lval=%b d=%h",
                             ln, x, pf[i], pl[i], pd[i], (x < HA), ((x < HA) ? 12'(x) : 12'h000));
                end
            end
            checks++; if (lc !== HA) begin failures++; $display("FAIL lval_count_l%0d got=%0d exp=16", ln, lc); end
        end
        n = 0;
        for (int j = VA * HT; j < NPIX; j++) if (!pf[j] && !pl[j] && pd[j] == 12'h000) n++;
        checks++; if (n !== 40) begin failures++; $display("FAIL vblank_len got=%0d exp=40", n); end
        capture_frame(-1, -1, 2'd0);
        checks++; if (start_cyc - s0 !== 240) begin failures++; $display("FAIL frame_period got=%0d exp=240", start_cyc - s0); end
    endtask

    task automatic test_counters();
        int d0, w0, bad;
        do_reset();
        enable = 1'b1;
        d0 = done_cnt;
        w0 = done_wide;
        repeat (3) capture_frame(-1, -1, 2'd0);
        checks++; if (cap_timeout !== 1'b0) begin failures++; $display("FAIL cnt_timeout got=1 exp=0"); end
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL frame_cnt got=%0d exp=3", frame_cnt); end
        checks++; if (done_cnt - d0 !== 3) begin failures++; $display("FAIL done_pulses got=%0d exp=3", done_cnt - d0); end
        checks++; if (done_wide - w0 !== 0) begin failures++; $display("FAIL done_width wide=%0d exp=0", done_wide - w0); end
        mode = 2'd3;
        capture_frame(-1, -1, 2'd0);
        bad = 0;
        for (int j = 0; j < VA * HT; j++)
            if (pd[j] !== ((j % HT < HA) ? 12'h003 : 12'h000)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL fcnt_pattern bad=%0d exp=0 first_pix=%h exp=003", bad, pd[0]); end
    endtask

    task automatic test_patterns();
        do_reset();
        mode   = 2'd1;
        enable = 1'b1;
        capture_frame(-1, -1, 2'd0);
        checks++; if (pd[0] !== 12'h000) begin failures++; $display("FAIL bars_p0 got=%h exp=000", pd[0]); end
        checks++; if (pd[1] !== 12'h000) begin failures++; $display("FAIL bars_p1 got=%h exp=000", pd[1]); end
        checks++; if (pd[14] !== 12'hFFF) begin failures++; $display("FAIL bars_p14 got=%h exp=fff", pd[14]); end
        checks++; if (pd[15] !== 12'hFFF) begin failures++; $display("FAIL bars_p15 got=%h exp=fff", pd[15]); end
        checks++; if (pd[4] !== EXP_P4) begin failures++; $display("FAIL bars_p4 got=%h exp=%h", pd[4], EXP_P4); end
        checks++; if (pd[HT + 2] !== EXP_L1P2) begin failures++; $display("FAIL bars_l1p2 got=%h exp=%h", pd[HT + 2], EXP_L1P2); end
        mode = 2'd2;
        capture_frame(-1, -1, 2'd0);
        checks++; if (pd[8] !== 12'hFFF) begin failures++; $display("FAIL check_p8 got=%h exp=fff", pd[8]); end
        checks++; if (pd[7] !== 12'h000) begin failures++; $display("FAIL check_p7 got=%h exp=000", pd[7]); end
        checks++; if (pd[3 * HT + 15] !== 12'hFFF) begin failures++; $display("FAIL check_l3p15 got=%h exp=fff", pd[3 * HT + 15]); end
    endtask

    task automatic test_enable_drop();
        int d0, n, bad;
        do_reset();
        enable = 1'b1;
        d0 = done_cnt;
        capture_frame(HT + 5, -1, 2'd0);
        n = 0;
        for (int j = 2 * HT; j < VA * HT; j++) if (pl[j]) n++;
        checks++; if (n !== 32) begin failures++; $display("FAIL drop_lines23 lval=%0d exp=32", n); end
        checks++; if (pd[3 * HT + 15] !== 12'd15) begin failures++; $display("FAIL drop_l3p15 got=%h exp=00f", pd[3 * HT + 15]); end
        n = 0;
        for (int j = VA * HT; j < NPIX; j++) if (!pf[j]) n++;
        checks++; if (n !== 40) begin failures++; $display("FAIL drop_vblank got=%0d exp=40", n); end
        bad = 0;
        repeat (300) begin
            next_pix();
            if (cam_fval !== 1'b0 || cam_lval !== 1'b0 || cam_d !== 12'h000) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL drop_idle bad=%0d exp=0", bad); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL drop_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_mode_change();
        do_reset();
        enable = 1'b1;
        capture_frame(-1, 2 * HT + 3, 2'd2);
        checks++; if (pd[2 * HT + 8] !== 12'd8) begin failures++; $display("FAIL chg_l2p8 got=%h exp=008", pd[2 * HT + 8]); end
        checks++; if (pd[3 * HT + 9] !== 12'd9) begin failures++; $display("FAIL chg_l3p9 got=%h exp=009", pd[3 * HT + 9]); end
        capture_frame(-1, -1, 2'd0);
        checks++; if (pd[8] !== 12'hFFF) begin failures++; $display("FAIL chg_next_p8 got=%h exp=fff", pd[8]); end
        checks++; if (pd[2 * HT + 2] !== 12'h000) begin failures++; $display("FAIL chg_next_l2p2 got=%h exp=000", pd[2 * HT + 2]); end
    endtask

    task automatic test_async_reset();
        bit got;
        int e_cyc;
        do_reset();
        enable = 1'b1;
        capture_frame(-1, -1, 2'd0);
        next_pix();
        checks++; if (cam_fval !== 1'b1) begin failures++; $display("FAIL ar_frame2_start got=%b exp=1", cam_fval); end
        repeat (2 * HT + 5) next_pix();
        checks++; if (cam_d !== 12'd5 || frame_cnt !== 16'd1) begin failures++; $display("FAIL ar_pre d=%h fcnt=%0d exp d=005 fcnt=1", cam_d, frame_cnt); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (cam_pixclk !== 1'b0 || cam_fval !== 1'b0 || cam_lval !== 1'b0 || cam_d !== 12'h000 ||
            frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL ar_outputs got pixclk=%b fval=%b lval=%b d=%h done=%b fcnt=%0d exp all 0",
                     cam_pixclk, cam_fval, cam_lval, cam_d, frame_done, frame_cnt);
        end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        got = 1'b0;
        repeat (30) begin
            next_pix();
            if (cam_fval !== 1'b0) got = 1'b1;
        end
        checks++; if (got !== 1'b0) begin failures++; $display("FAIL ar_no_fval got=1 exp=0"); end
        enable = 1'b1;
        e_cyc = cyc;
        got = 1'b0;
        repeat (4) begin
            next_pix();
            if (cam_fval) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1 || cyc - e_cyc > 3) begin failures++; $display("FAIL ar_latency got=%0d clk exp<=3 seen=%b", cyc - e_cyc, got); end
        checks++; if (cam_lval !== 1'b1 || cam_d !== 12'h000) begin failures++; $display("FAIL ar_first_pix lval=%b d=%h exp lval=1 d=000", cam_lval, cam_d); end
        next_pix();
        checks++; if (cam_d !== 12'h001) begin failures++; $display("FAIL ar_second_pix got=%h exp=001", cam_d); end
    endtask

    initial begin
        test_reset();
        test_framing();
        test_counters();
        test_patterns();
        test_enable_drop();
        test_mode_change();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
